// File: rtl/cpu_types_pkg.sv
// Shared datapath/cache types: word, dcache address split, frame layout, responder states.
// Pure type/constant definitions, no logic.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int DC_SETS = 16;
    localparam int DC_IDXW = 4;
    localparam int DC_TAGW = 32 - 3 - DC_IDXW;

    typedef struct packed {
        logic [DC_TAGW-1:0] tag;
        logic [DC_IDXW-1:0] idx;
        logic               blkoff;
        logic [1:0]         bytoff;
    } dcache_addr_t;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [DC_TAGW-1:0] tag;
        word_t [1:0]        data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, DONE
    } dcache_state_t;

    function automatic word_t dc_word_addr(input logic [DC_TAGW-1:0] tag,
                                           input logic [DC_IDXW-1:0] idx,
                                           input logic               blk);
        return {tag, idx, blk, 2'b00};
    endfunction

endpackage

// File: rtl/dcache_frame_array.sv
// Direct-mapped frame storage: one combinational read port, one write port with per-field enables.
// Writes land on the rising edge; reset clears every frame (invalid, clean).
module dcache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int IDXW = DC_IDXW
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IDXW-1:0] rd_idx_i,
    output dcache_frame_t   rd_frame_o,
    input  logic [IDXW-1:0] wr_idx_i,
    input  logic            wr_valid_en_i,
    input  logic            wr_dirty_en_i,
    input  logic            wr_tag_en_i,
    input  logic [1:0]      wr_data_en_i,
    input  dcache_frame_t   wr_frame_i
);

    dcache_frame_t frames_q [SETS];

    assign rd_frame_o = frames_q[rd_idx_i];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < SETS; i++) begin
                frames_q[i] <= '0;
            end
        end else begin
            if (wr_valid_en_i)   frames_q[wr_idx_i].valid   <= wr_frame_i.valid;
            if (wr_dirty_en_i)   frames_q[wr_idx_i].dirty   <= wr_frame_i.dirty;
            if (wr_tag_en_i)     frames_q[wr_idx_i].tag     <= wr_frame_i.tag;
            if (wr_data_en_i[0]) frames_q[wr_idx_i].data[0] <= wr_frame_i.data[0];
            if (wr_data_en_i[1]) frames_q[wr_idx_i].data[1] <= wr_frame_i.data[1];
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate dcache: 0-cycle hits in IDLE, blocking word-serial miss path,
// flush of all dirty frames on halt. Memory requests hold stable while dwait is high.
module dcache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS = DC_SETS,
    parameter int IDXW = DC_IDXW
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    input  logic  halt,
    output logic  dhit,
    output word_t dmemload,
    output logic  flushed,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    input  word_t dload,
    input  logic  dwait
);

    dcache_state_t   state_q, state_d;
    logic [IDXW-1:0] fidx_q, fidx_d;

    dcache_addr_t    req;
    dcache_frame_t   frame;
    logic [IDXW-1:0] rd_idx;
    logic            req_vld, tag_hit, flush_st, last_idx;

    logic            wr_valid_en, wr_dirty_en, wr_tag_en;
    logic [1:0]      wr_data_en;
    dcache_frame_t   wr_frame;

    assign req      = dcache_addr_t'(dmemaddr);
    assign req_vld  = dmemREN | dmemWEN;
    // Flush walks the array by its own index; everything else is addressed by the request.
    assign flush_st = (state_q == FLUSH) || (state_q == FWB0) || (state_q == FWB1);
    assign rd_idx   = flush_st ? fidx_q : req.idx;
    assign tag_hit  = frame.valid && (frame.tag == req.tag);
    assign last_idx = (fidx_q == IDXW'(SETS - 1));

    dcache_frame_array #(
        .SETS (SETS),
        .IDXW (IDXW)
    ) u_frames (
        .CLK           (CLK),
        .RST           (RST),
        .rd_idx_i      (rd_idx),
        .rd_frame_o    (frame),
        .wr_idx_i      (rd_idx),
        .wr_valid_en_i (wr_valid_en),
        .wr_dirty_en_i (wr_dirty_en),
        .wr_tag_en_i   (wr_tag_en),
        .wr_data_en_i  (wr_data_en),
        .wr_frame_i    (wr_frame)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            fidx_q  <= fidx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fidx_d      = fidx_q;
        dhit        = 1'b0;
        dmemload    = '0;
        flushed     = 1'b0;
        dREN        = 1'b0;
        dWEN        = 1'b0;
        daddr       = '0;
        dstore      = '0;
        wr_valid_en = 1'b0;
        wr_dirty_en = 1'b0;
        wr_tag_en   = 1'b0;
        wr_data_en  = '0;
        wr_frame    = '0;

        unique case (state_q)
            IDLE: begin
                if (req_vld) begin
                    if (tag_hit) begin
                        dhit = 1'b1;
                        if (dmemWEN) begin
                            wr_data_en[req.blkoff]    = 1'b1;
                            wr_frame.data[req.blkoff] = dmemstore;
                            wr_dirty_en               = 1'b1;
                            wr_frame.dirty            = 1'b1;
                        end else begin
                            dmemload = frame.data[req.blkoff];
                        end
                    end else if (frame.valid && frame.dirty) begin
                        state_d = WB0;
                    end else begin
                        state_d = LD0;
                    end
                end else if (halt) begin
                    state_d = FLUSH;
                    fidx_d  = '0;
                end
            end
            WB0, FWB0: begin
                dWEN   = 1'b1;
                daddr  = dc_word_addr(frame.tag, rd_idx, 1'b0);
                dstore = frame.data[0];
                if (!dwait) state_d = (state_q == WB0) ? WB1 : FWB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = dc_word_addr(frame.tag, rd_idx, 1'b1);
                dstore = frame.data[1];
                if (!dwait) state_d = LD0;
            end
            FWB1: begin
                dWEN   = 1'b1;
                daddr  = dc_word_addr(frame.tag, rd_idx, 1'b1);
                dstore = frame.data[1];
                if (!dwait) begin
                    wr_dirty_en = 1'b1;
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        fidx_d  = fidx_q + IDXW'(1);
                        state_d = FLUSH;
                    end
                end
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = dc_word_addr(req.tag, req.idx, 1'b0);
                if (!dwait) begin
                    wr_data_en[0]    = 1'b1;
                    wr_frame.data[0] = dload;
                    state_d          = LD1;
                end
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = dc_word_addr(req.tag, req.idx, 1'b1);
                if (!dwait) begin
                    wr_data_en[1]    = 1'b1;
                    wr_frame.data[1] = dload;
                    wr_valid_en      = 1'b1;
                    wr_dirty_en      = 1'b1;
                    wr_tag_en        = 1'b1;
                    wr_frame.valid   = 1'b1;
                    wr_frame.tag     = req.tag;
                    state_d          = IDLE;
                end
            end
            FLUSH: begin
                if (frame.valid && frame.dirty) begin
                    state_d = FWB0;
                end else if (last_idx) begin
                    state_d = DONE;
                end else begin
                    fidx_d = fidx_q + IDXW'(1);
                end
            end
            DONE: begin
                flushed = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_responder.sv
`timescale 1ns/1ps
module tb_dcache_responder;
    import cpu_types_pkg::*;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    logic  dmemREN = 1'b0, dmemWEN = 1'b0, halt = 1'b0, dwait = 1'b0;
    word_t dmemaddr = '0, dmemstore = '0, dload = '0;
    logic  dhit, flushed, dREN, dWEN;
    word_t dmemload, daddr, dstore;

    dcache_responder dut (
        .CLK       (CLK),
        .RST       (RST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .halt      (halt),
        .dhit      (dhit),
        .dmemload  (dmemload),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait)
    );

    always #5 CLK = ~CLK;

    typedef struct packed { logic we; word_t addr; word_t data; } xfer_t;
    typedef struct packed { logic we; word_t data; } resp_t;

    xfer_t xq[$];
    resp_t hq[$];
    word_t mem [word_t];
    int    n_cmp = 0;
    int    n_bad = 0;
    xfer_t m_xa, m_xe;
    resp_t m_ra, m_re;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic word_t init_word(input word_t a);
        return 32'hC000_0000 | a;
    endfunction

    function automatic word_t mem_rd(input word_t a);
        return mem.exists(a) ? mem[a] : init_word(a);
    endfunction

    function automatic xfer_t rd_x(input word_t a);
        return '{we: 1'b0, addr: a, data: 32'h0};
    endfunction

    function automatic xfer_t wr_x(input word_t a, input word_t d);
        return '{we: 1'b1, addr: a, data: d};
    endfunction

    // Monitor: every completed bus transfer and every dhit is matched against the expected queues.
    always @(negedge CLK) begin
        if (!RST) begin
            if (dREN && dWEN) check("ren_wen_exclusive", 65'd1, 65'd0);
            if ((dREN || dWEN) && !dwait) begin
                m_xa = '{we: dWEN, addr: daddr, data: (dWEN ? dstore : 32'h0)};
                if (xq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL xfer_unexpected: got %0h expected none", m_xa);
                end else begin
                    m_xe = xq.pop_front();
                    check("xfer", 65'(m_xa), 65'(m_xe));
                end
                if (dWEN) mem[daddr] = dstore;
            end
            if (dhit) begin
                m_ra = '{we: dmemWEN, data: (dmemWEN ? 32'h0 : dmemload)};
                if (hq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL hit_unexpected: got %0h expected none", m_ra);
                end else begin
                    m_re = hq.pop_front();
                    check("hit_resp", 65'(m_ra), 65'(m_re));
                end
            end
        end
        // Garbage on the bus while stalled catches any premature capture.
        dload = dwait ? 32'hBAD0_BAD0 : mem_rd(daddr);
    end

    task automatic issue(input logic ren, input logic wen, input word_t a, input word_t d);
        dmemREN   = ren;
        dmemWEN   = wen;
        dmemaddr  = a;
        dmemstore = d;
    endtask

    task automatic wait_hit(input string name, output int lat);
        bit got;
        got = 0;
        lat = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge CLK);
            if (dhit) begin
                got = 1;
            end else begin
                @(posedge CLK);
                lat++;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: got no dhit expected dhit within 100 cycles", name);
        end
        @(posedge CLK);
        #1;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic req(input string name, input logic wen, input word_t a, input word_t d, input int exp_lat);
        int lat;
        issue(!wen, wen, a, d);
        wait_hit(name, lat);
        check({name, "_latency"}, 65'(lat), 65'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;
        mem[32'h40] = 32'hAAAA_0000;
        mem[32'h44] = 32'hBBBB_0004;

        // Reset values
        repeat (2) @(negedge CLK);
        check("reset_ctrl", 65'({dhit, flushed, dREN, dWEN}), 65'd0);
        check("reset_data", 65'({dmemload, daddr}), 65'd0);
        check("reset_dstore", 65'(dstore), 65'd0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Clean miss fill: LD0 0x40, LD1 0x44, hit on the third cycle
        xq.push_back(rd_x(32'h40));
        xq.push_back(rd_x(32'h44));
        hq.push_back('{we: 1'b0, data: 32'hAAAA_0000});
        req("load_40", 1'b0, 32'h40, 32'h0, 3);

        // Same block, other word: immediate hit
        hq.push_back('{we: 1'b0, data: 32'hBBBB_0004});
        req("load_44", 1'b0, 32'h44, 32'h0, 0);

        // Write hit, then conflicting tag forces write-back of both words and refill
        hq.push_back('{we: 1'b1, data: 32'h0});
        req("store_40", 1'b1, 32'h40, 32'h1234_5678, 0);
        xq.push_back(wr_x(32'h40, 32'h1234_5678));
        xq.push_back(wr_x(32'h44, 32'hBBBB_0004));
        xq.push_back(rd_x(32'h440));
        xq.push_back(rd_x(32'h444));
        hq.push_back('{we: 1'b0, data: init_word(32'h440)});
        req("load_440", 1'b0, 32'h440, 32'h0, 5);

        // dwait held for five cycles in LD0
        dwait = 1'b1;
        xq.push_back(rd_x(32'h40));
        xq.push_back(rd_x(32'h44));
        hq.push_back('{we: 1'b0, data: 32'h1234_5678});
        issue(1'b1, 1'b0, 32'h40, 32'h0);
        @(posedge CLK);
        #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("dwait_hold", 65'({dREN, dWEN, daddr}), 65'({1'b1, 1'b0, 32'h40}));
        end
        @(posedge CLK);
        #1 dwait = 1'b0;
        wait_hit("load_40_stalled", lat);
        check("load_40_stalled_latency", 65'(lat), 65'd2);

        // Dirty frames at idx 2 and idx 15
        xq.push_back(rd_x(32'h10));
        xq.push_back(rd_x(32'h14));
        hq.push_back('{we: 1'b1, data: 32'h0});
        req("store_10", 1'b1, 32'h10, 32'h2222_2222, 3);
        xq.push_back(rd_x(32'h78));
        xq.push_back(rd_x(32'h7C));
        hq.push_back('{we: 1'b1, data: 32'h0});
        req("store_7c", 1'b1, 32'h7C, 32'hFFFF_0001, 3);

        // Halt: four write-backs in index order, then flushed held
        xq.push_back(wr_x(32'h10, 32'h2222_2222));
        xq.push_back(wr_x(32'h14, init_word(32'h14)));
        xq.push_back(wr_x(32'h78, init_word(32'h78)));
        xq.push_back(wr_x(32'h7C, 32'hFFFF_0001));
        halt = 1'b1;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge CLK);
            if (flushed) seen = 1;
        end
        check("flushed_reached", 65'(seen), 65'd1);
        check("flush_xfer_count", 65'(xq.size()), 65'd0);
        halt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("flushed_hold", 65'({flushed, dREN, dWEN, dhit}), 65'b1000);
        end

        // Reset out of DONE, then abort a miss during WB1
        @(posedge CLK);
        #1 RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        check("flushed_cleared", 65'(flushed), 65'd0);
        xq.push_back(rd_x(32'h40));
        xq.push_back(rd_x(32'h44));
        hq.push_back('{we: 1'b0, data: 32'h1234_5678});
        req("reload_40", 1'b0, 32'h40, 32'h0, 3);
        hq.push_back('{we: 1'b1, data: 32'h0});
        req("store_40_b", 1'b1, 32'h40, 32'h5555_5555, 0);
        xq.push_back(wr_x(32'h40, 32'h5555_5555));
        issue(1'b1, 1'b0, 32'h440, 32'h0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge CLK);
            if (dWEN) seen = 1;
        end
        check("wb0_seen", 65'(seen), 65'd1);
        @(posedge CLK);
        #1 dwait = 1'b1;
        @(negedge CLK);
        check("wb1_bus", 65'({dWEN, daddr, dstore}), 65'({1'b1, 32'h44, 32'hBBBB_0004}));
        #1 RST = 1'b1;
        issue(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rst_drops_request", 65'({dREN, dWEN, dhit}), 65'd0);
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        dwait = 1'b0;

        // All frames invalid after reset: clean miss, no write-back
        xq.push_back(rd_x(32'h440));
        xq.push_back(rd_x(32'h444));
        hq.push_back('{we: 1'b0, data: init_word(32'h440)});
        req("load_440_after_rst", 1'b0, 32'h440, 32'h0, 3);

        repeat (2) @(negedge CLK);
        check("xfer_queue_drained", 65'(xq.size()), 65'd0);
        check("hit_queue_drained", 65'(hq.size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
